// File: rtl/wb_uart_pkg.sv
// ============================================================================
// wb_uart_pkg : shared constants and types for the Wishbone UART receiver
// Revision    : 1.0
// ============================================================================
`default_nettype none

package wb_uart_pkg;

  // Byte offsets within the 16-byte register window (address bits [3:2])
  localparam logic [3:0] DATA_OFF   = 4'h0;
  localparam logic [3:0] STATUS_OFF = 4'h4;
  localparam logic [3:0] DIV_OFF    = 4'h8;

  localparam int ST_VALID  = 0;
  localparam int ST_CNT_LO = 1;
  localparam int ST_CNT_HI = 3;
  localparam int ST_OVR    = 4;
  localparam int ST_FERR   = 5;

  // 50 MHz / 115200 baud
  localparam int unsigned DEFAULT_DIV = 434;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/wb_uart_rx_sync_fifo.sv
// ============================================================================
// sync_fifo : power-of-two circular receive buffer with separate occupancy count
// Revision  : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A pop in the same cycle frees the slot, so a full FIFO may still accept
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_uart_rx.sv
// ============================================================================
// wb_uart_rx : Wishbone-slave 8N1 UART receiver with a small receive FIFO
// Revision   : 1.0
// ============================================================================
`default_nettype none

module wb_uart_rx
  import wb_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_DIV,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        rx_i,
  output logic        irq_o
);

  localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] DIV_RST = 16'(CLKS_PER_BIT);

  logic        r_rx_meta;
  logic        r_rx_sync;
  logic        r_rx_prev;
  rx_state_t   r_state;
  logic [15:0] r_cnt;
  logic [15:0] r_div_q;
  logic [15:0] r_div;
  logic [7:0]  r_shift;
  logic [2:0]  r_bit;
  logic        r_ovr;
  logic        r_ferr;
  logic        r_ack;
  logic [31:0] r_dat;
  logic        r_irq;

  logic          w_req;
  logic [3:0]    w_off;
  logic          w_pop;
  logic          w_expire;
  logic          w_stop_smp;
  logic          w_push;
  logic          w_ovr_evt;
  logic          w_ferr_evt;
  logic          w_st_wr;
  logic          w_div_wr;
  logic [15:0]   w_div_new;
  logic [7:0]    w_rdata;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [31:0]   w_status;
  logic [31:0]   w_rd_word;
  logic          w_unused;

  assign w_unused = &{1'b0, wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2]};

  // ---------------------------------------------------------------- decode
  assign w_req    = wbs_cyc_i && wbs_stb_i && !r_ack;
  assign w_off    = {wbs_adr_i[3:2], 2'b00};
  assign w_pop    = w_req && !wbs_we_i && (w_off == DATA_OFF);
  assign w_st_wr  = w_req && wbs_we_i && (w_off == STATUS_OFF);
  assign w_div_wr = w_req && wbs_we_i && (w_off == DIV_OFF);
  assign w_div_new = {wbs_sel_i[1] ? wbs_dat_i[15:8] : r_div[15:8],
                      wbs_sel_i[0] ? wbs_dat_i[7:0]  : r_div[7:0]};

  always_comb begin
    w_status                       = '0;
    w_status[ST_VALID]             = !w_empty;
    w_status[ST_CNT_HI:ST_CNT_LO]  = 3'(w_count);
    w_status[ST_OVR]               = r_ovr;
    w_status[ST_FERR]              = r_ferr;
  end

  always_comb begin
    w_rd_word = '0;
    case (w_off)
      DATA_OFF:   w_rd_word = w_empty ? 32'd0 : {24'd0, w_rdata};
      STATUS_OFF: w_rd_word = w_status;
      DIV_OFF:    w_rd_word = {16'd0, r_div};
      default:    w_rd_word = '0;
    endcase
  end

  // -------------------------------------------------------------- receiver
  assign w_expire   = (r_cnt == 16'd0);
  assign w_stop_smp = (r_state == STOP) && w_expire;
  assign w_push     = w_stop_smp && r_rx_sync;
  assign w_ovr_evt  = w_push && w_full && !w_pop;
  assign w_ferr_evt = w_stop_smp && !r_rx_sync;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_div_q   <= DIV_RST;
      r_shift   <= '0;
      r_bit     <= '0;
    end else begin
      r_rx_meta <= rx_i;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      // Reload with div_q-1 so consecutive samples are exactly div_q cycles apart
      case (r_state)
        IDLE: begin
          if (r_rx_prev && !r_rx_sync) begin
            r_div_q <= r_div;
            r_cnt   <= r_div >> 1;
            r_state <= START;
          end
        end
        START: begin
          if (w_expire) begin
            if (!r_rx_sync) begin
              r_cnt   <= r_div_q - 16'd1;
              r_bit   <= '0;
              r_state <= DATA;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        DATA: begin
          if (w_expire) begin
            r_shift <= {r_rx_sync, r_shift[7:1]};
            r_cnt   <= r_div_q - 16'd1;
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= STOP;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        STOP: begin
          if (w_expire) r_state <= IDLE;
          else          r_cnt   <= r_cnt - 16'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // ------------------------------------------------------- registers / bus
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ack  <= 1'b0;
      r_dat  <= '0;
      r_irq  <= 1'b0;
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
      r_div  <= DIV_RST;
    end else begin
      r_ack <= w_req;
      r_dat <= (w_req && !wbs_we_i) ? w_rd_word : 32'd0;
      r_irq <= !w_empty || r_ovr || r_ferr;

      if (w_ovr_evt)                             r_ovr <= 1'b1;
      else if (w_st_wr && wbs_dat_i[ST_OVR])     r_ovr <= 1'b0;

      if (w_ferr_evt)                            r_ferr <= 1'b1;
      else if (w_st_wr && wbs_dat_i[ST_FERR])    r_ferr <= 1'b0;

      if (w_div_wr && (w_div_new >= 16'd4))      r_div <= w_div_new;
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .i_push  (w_push),
    .i_wdata (r_shift),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign irq_o     = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_wb_uart_rx.sv
// ============================================================================
// tb_wb_uart_rx : self-checking bench for wb_uart_rx (directed + randomized)
// Revision      : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_wb_uart_rx;

  localparam int DEPTH = 4;
  localparam logic [3:0] O_DATA = 4'h0, O_STAT = 4'h4, O_DIV = 4'h8, O_RSVD = 4'hC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic        rx = 1'b1;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: a byte queue plus the two sticky flags
  byte unsigned m_q[$];
  bit           m_ovr, m_ferr;

  always #5 clk = ~clk;

  wb_uart_rx dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .rx_i      (rx),
    .irq_o     (irq)
  );

  // ------------------------------------------------------------ bus access
  task automatic wb_xfer(input logic w, input logic [3:0] off, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] q);
    bit got = 0;
    q = '0;
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = w; adr = 32'h3000_0000 | {28'd0, off}; wdat = d; sel = s;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) begin got = 1; q = rdat; end
    end
    cyc = 0; stb = 0; we = 0;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL wb_ack_timeout: ack=%0b required=1 off=%h", ack, off);
    end
  endtask

  task automatic wb_read(input logic [3:0] off, output logic [31:0] q);
    wb_xfer(1'b0, off, 32'h0, 4'hF, q);
  endtask

  task automatic wb_write(input logic [3:0] off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    wb_xfer(1'b1, off, d, s, dummy);
  endtask

  // ---------------------------------------------------------- serial driver
  task automatic send_frame(input byte unsigned b, input bit stop, input int div);
    @(negedge clk); rx = 1'b0;
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (div) @(negedge clk);
    end
    rx = stop;
    repeat (div) @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  function automatic void mdl_frame(input byte unsigned b, input bit stop);
    if (!stop)                 m_ferr = 1;
    else if (m_q.size() < DEPTH) m_q.push_back(b);
    else                       m_ovr = 1;
  endfunction

  function automatic logic [31:0] mdl_status();
    return {26'd0, m_ferr, m_ovr, 3'(m_q.size()), m_q.size() != 0};
  endfunction

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    logic [31:0] q;
    rst_n = 0; rx = 1;
    repeat (5) @(posedge clk); #1;
    n_checks++; if (ack !== 1'b0)  begin n_fail++; $display("FAIL rst_ack: got %b required 0", ack); end
    n_checks++; if (rdat !== 32'd0) begin n_fail++; $display("FAIL rst_dat: got %h required 0", rdat); end
    n_checks++; if (irq !== 1'b0)  begin n_fail++; $display("FAIL rst_irq: got %b required 0", irq); end
    @(negedge clk); rst_n = 1;
    repeat (3) @(posedge clk);
    wb_read(O_STAT, q);
    n_checks++; if (q !== 32'h0) begin n_fail++; $display("FAIL rst_status: got %h required 0", q); end
    wb_read(O_DIV, q);
    n_checks++; if (q !== 32'd434) begin n_fail++; $display("FAIL rst_div: got %0d required 434", q); end
    wb_read(O_RSVD, q);
    n_checks++; if (q !== 32'h0) begin n_fail++; $display("FAIL rsvd_read: got %h required 0", q); end
    wb_read(O_DATA, q);
    n_checks++; if (q !== 32'h0) begin n_fail++; $display("FAIL empty_data: got %h required 0", q); end
    wb_read(O_STAT, q);
    n_checks++; if (q !== 32'h0) begin n_fail++; $display("FAIL empty_pop_status: got %h required 0", q); end
  endtask

  task automatic test_single_frame();
    logic [31:0] q;
    send_frame(8'h5A, 1'b1, 434);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL single_irq: got %b required 1", irq); end
    wb_read(O_STAT, q);
    n_checks++; if (q !== 32'h03) begin n_fail++; $display("FAIL single_status: got %h required 03", q); end
    wb_read(O_DATA, q);
    n_checks++; if (q !== 32'h5A) begin n_fail++; $display("FAIL single_data: got %h required 5a", q); end
    wb_read(O_STAT, q);
    n_checks++; if (q !== 32'h00) begin n_fail++; $display("FAIL single_status_after: got %h required 00", q); end
    repeat (2) @(posedge clk); #1;
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL single_irq_fall: got %b required 0", irq); end
  endtask

  task automatic test_glitch();
    logic [31:0] q;
    @(negedge clk); rx = 0;
    repeat (100) @(negedge clk);
    rx = 1;
    repeat (500) @(negedge clk);
    wb_read(O_STAT, q);
    n_checks++; if (q !== 32'h00) begin n_fail++; $display("FAIL glitch_status: got %h required 00", q); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL glitch_irq: got %b required 0", irq); end
    send_frame(8'h96, 1'b1, 434);
    wb_read(O_DATA, q);
    n_checks++; if (q !== 32'h96) begin n_fail++; $display("FAIL glitch_next_frame: got %h required 96", q); end
  endtask

  task automatic test_frame_error();
    logic [31:0] q;
    send_frame(8'h3C, 1'b0, 434);
    wb_read(O_STAT, q);
    n_checks++; if (q !== 32'h20) begin n_fail++; $display("FAIL ferr_status: got %h required 20", q); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL ferr_irq: got %b required 1", irq); end
    wb_write(O_STAT, 32'h20, 4'hF);
    repeat (2) @(posedge clk); #1;
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL ferr_irq_clear: got %b required 0", irq); end
    wb_read(O_STAT, q);
    n_checks++; if (q !== 32'h00) begin n_fail++; $display("FAIL ferr_cleared: got %h required 00", q); end
  endtask

  task automatic test_overrun();
    logic [31:0] q;
    logic [31:0] exp_d [5] = '{32'h01, 32'h02, 32'h03, 32'h04, 32'h00};
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 434);
    wb_read(O_STAT, q);
    n_checks++; if (q !== 32'h19) begin n_fail++; $display("FAIL ovr_status: got %h required 19", q); end
    for (int i = 0; i < 5; i++) begin
      wb_read(O_DATA, q);
      n_checks++;
      if (q !== exp_d[i]) begin n_fail++; $display("FAIL ovr_data[%0d]: got %h required %h", i, q, exp_d[i]); end
    end
    wb_read(O_STAT, q);
    n_checks++; if (q !== 32'h10) begin n_fail++; $display("FAIL ovr_sticky: got %h required 10", q); end
    wb_write(O_STAT, 32'h10, 4'h0);
    wb_read(O_STAT, q);
    n_checks++; if (q !== 32'h00) begin n_fail++; $display("FAIL ovr_clear: got %h required 00", q); end
  endtask

  task automatic test_divisor();
    logic [31:0] q;
    wb_write(O_DIV, 32'd217, 4'b0011);
    wb_read(O_DIV, q);
    n_checks++; if (q !== 32'd217) begin n_fail++; $display("FAIL div_write: got %0d required 217", q); end
    send_frame(8'hA5, 1'b1, 217);
    wb_read(O_DATA, q);
    n_checks++; if (q !== 32'hA5) begin n_fail++; $display("FAIL div_data: got %h required a5", q); end
    wb_write(O_DIV, 32'd2, 4'b0011);
    wb_read(O_DIV, q);
    n_checks++; if (q !== 32'd217) begin n_fail++; $display("FAIL div_min_ignored: got %0d required 217", q); end
    wb_write(O_DIV, 32'hFFFF_0155, 4'b0010);
    wb_read(O_DIV, q);
    n_checks++; if (q !== 32'h1D9) begin n_fail++; $display("FAIL div_sel_hi: got %h required 1d9", q); end
    wb_write(O_DIV, 32'h0000_00D9, 4'b0001);
    wb_read(O_DIV, q);
    n_checks++; if (q !== 32'h1D9) begin n_fail++; $display("FAIL div_sel_lo: got %h required 1d9", q); end
    wb_write(O_DIV, 32'h0000_00D9, 4'b0011);
  endtask

  task automatic test_reset_midframe();
    logic [31:0] q;
    // start bit and data bits 0..3 of 0x00 at divisor 217, then reset during bit 4
    @(negedge clk); rx = 1'b0;
    repeat (5 * 217 + 100) @(negedge clk);
    rst_n = 0; rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1;
    repeat (300) @(negedge clk);
    wb_read(O_STAT, q);
    n_checks++; if (q !== 32'h00) begin n_fail++; $display("FAIL rstmid_status: got %h required 00", q); end
    wb_read(O_DIV, q);
    n_checks++; if (q !== 32'd434) begin n_fail++; $display("FAIL rstmid_div: got %0d required 434", q); end
    send_frame(8'h77, 1'b1, 434);
    wb_read(O_DATA, q);
    n_checks++; if (q !== 32'h77) begin n_fail++; $display("FAIL rstmid_data: got %h required 77", q); end
    wb_read(O_STAT, q);
    n_checks++; if (q !== 32'h00) begin n_fail++; $display("FAIL rstmid_status_after: got %h required 00", q); end
  endtask

  task automatic test_random();
    logic [31:0] q, e, d;
    int div;
    byte unsigned b;
    bit stop, e_irq;
    m_q.delete(); m_ovr = 0; m_ferr = 0;
    div = $urandom_range(8, 40);
    wb_write(O_DIV, div, 4'b0011);
    for (int it = 0; it < 24; it++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      send_frame(b, stop, div);
      mdl_frame(b, stop);
      e_irq = (m_q.size() != 0) || m_ovr || m_ferr;
      n_checks++;
      if (irq !== e_irq) begin n_fail++; $display("FAIL rnd_irq[%0d]: got %b required %b", it, irq, e_irq); end
      case ($urandom_range(0, 3))
        0: begin
          wb_read(O_DATA, q);
          e = (m_q.size() != 0) ? {24'd0, m_q.pop_front()} : 32'd0;
          n_checks++;
          if (q !== e) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h required %h", it, q, e); end
        end
        1: begin
          wb_read(O_STAT, q);
          e = mdl_status();
          n_checks++;
          if (q !== e) begin n_fail++; $display("FAIL rnd_status[%0d]: got %h required %h", it, q, e); end
        end
        2: begin
          d = $urandom;
          wb_write(O_STAT, d, 4'($urandom));
          if (d[4]) m_ovr  = 0;
          if (d[5]) m_ferr = 0;
        end
        default: ;
      endcase
    end
    wb_read(O_STAT, q);
    e = mdl_status();
    n_checks++;
    if (q !== e) begin n_fail++; $display("FAIL rnd_final_status: got %h required %h", q, e); end
    for (int i = 0; i <= DEPTH; i++) begin
      wb_read(O_DATA, q);
      e = (m_q.size() != 0) ? {24'd0, m_q.pop_front()} : 32'd0;
      n_checks++;
      if (q !== e) begin n_fail++; $display("FAIL rnd_drain[%0d]: got %h required %h", i, q, e); end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_divisor();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/wb_uart_rx.md
# wb_uart_rx

Wishbone-slave UART receiver for the user project area. It deserialises 8N1 frames arriving on a user GPIO (mprj_io[15]) and buffers the received bytes in a small FIFO that the management SoC drains over Wishbone. It is the receive end of the UART link whose transmit side drives mprj_io[16]. With it, firmware can echo and check serial traffic without bit-banging.

## Interface

Parameters:
- CLKS_PER_BIT, 434: reset value of the baud divisor (50 MHz / 115200).
- FIFO_DEPTH, 4: number of receive FIFO entries; must be a power of two.

Ports:
- wb_clk_i  in  1  single clock for the whole block.
- wb_rst_ni  in  1  reset, asynchronous assert, active-low.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects. Writes honour only sel[0]/sel[1] for DIVISOR.
- wbs_adr_i  in  32  address. Only bits [3:2] are decoded.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  transfer acknowledge.
- wbs_dat_o  out  32  read data.
- rx_i  in  1  serial input, asynchronous to wb_clk_i, idle high.
- irq_o  out  1  high while the FIFO is non-empty or any sticky error is set.

## Operation

Register map (word offsets):
- 0x0 DATA (read only): returns {24'b0, head byte} and pops the FIFO. A read while the FIFO is empty returns 0 and changes nothing.
- 0x4 STATUS: bit0 valid (FIFO non-empty), bits[3:1] count (0..FIFO_DEPTH), bit4 overrun (sticky), bit5 frame_err (sticky). Writing 1 to bit4 or bit5 clears that bit. All other bits read 0.
- 0x8 DIVISOR: bits[15:0], read/write. Writes of value < 4 are ignored.
- 0xC: reads 0, writes ignored.

Receiver datapath:
- rx_i passes through a 2-flop synchroniser (reset value 1). All logic uses the synchronised value.
- FSM states are IDLE, START, DATA, STOP.
- IDLE: on a synchronised falling edge, latch DIVISOR into div_q, load the counter with div_q/2, go to START.
- START: when the counter expires, sample the line. Low: reload the counter with div_q, go to DATA. High: treat as a glitch and return to IDLE with nothing logged.
- DATA: at each expiry, shift the sample into the shift register LSB-first and reload div_q. After the 8th sample, go to STOP.
- STOP: at expiry, sample the line.
  - 1 and FIFO not full: push the byte.
  - 1 and FIFO full: drop the byte and set overrun.
  - 0: discard the byte and set frame_err.
  - In all three cases go to IDLE. A new frame needs a fresh falling edge, so a held-low line is never re-read as a start bit.
- Counter is 16 bits and counts down. Expiry means value 0 on the cycle the sample is taken.

FIFO:
- Circular buffer with log2(FIFO_DEPTH)-bit read and write pointers that wrap modulo FIFO_DEPTH.
- Count is held separately, width log2(FIFO_DEPTH)+1.
- Push and pop in the same cycle: both take effect and count is unchanged. This is legal even when full; the push is accepted because the pop frees a slot, and overrun is not set.

## Timing

- Wishbone: ack_o rises in the cycle after cyc&stb is sampled high with ack_o low. It is a one-cycle pulse, so back-to-back accesses complete in 2 cycles each.
- wbs_dat_o is valid in the ack cycle and 0 otherwise. The DATA pop and all register writes take effect in the ack cycle.
- A frame is pushed in the cycle the stop-bit sample is taken, about 9.5·div_q + 3 cycles after the falling edge on rx_i.
  - valid is readable on the next cycle.
  - irq_o is registered: it rises 1 cycle after the push, error set, or error clear that makes it true.
- A DIVISOR write mid-frame affects only the next frame, because div_q is latched in IDLE.
- Reset values: ack_o 0, dat_o 0, irq_o 0, FSM IDLE, FIFO empty, pointers 0, overrun 0, frame_err 0, DIVISOR CLKS_PER_BIT, synchroniser 1.
- Reset asserted mid-frame aborts the frame. Reception resumes only on the next falling edge after reset is released.

## Structure

- Shared package wb_uart_pkg holds:
  - register offsets (DATA_OFF, STATUS_OFF, DIV_OFF);
  - STATUS bit indices;
  - the rx_state_t enum (IDLE, START, DATA, STOP);
  - the 115200 @ 50 MHz default divisor.
- One sub-module, sync_fifo, contains the FIFO storage, pointers and count, with push, pop, full, empty and count ports. The FSM, synchroniser and Wishbone decode stay in wb_uart_rx.

## Test plan

- Send 0x5A at divisor 434.
  - Response: irq_o rises; STATUS reads 0x03 (valid=1, count=1); DATA reads 0x5A; STATUS then reads 0x00; irq_o falls.
- Drive a 100-cycle low pulse on rx_i.
  - Response: no push, STATUS stays 0x00, FSM back in IDLE.
- Send 0x3C with the stop bit driven 0.
  - Response: STATUS reads 0x20, FIFO empty, irq_o high. Writing 0x20 to STATUS clears it and irq_o falls.
- Send 0x01..0x05 with no reads (FIFO_DEPTH=4).
  - Response: STATUS reads 0x19 (overrun=1, count=4, valid=1). DATA reads 0x01, 0x02, 0x03, 0x04, then 0x00 when empty.
- Write DIVISOR=217, then send 0xA5 at 230400 baud.
  - Response: DATA reads 0xA5. A DIVISOR write of 2 is ignored and DIVISOR still reads 217.
- Assert wb_rst_ni during bit 4 of a frame, release, then send 0x77.
  - Response: the first frame is lost, DIVISOR is back to 434, DATA reads 0x77.
